// File: rtl/led_pkg.sv
// led_pkg: shared definitions for the LED pattern generator.
//   mode_t         - 2-bit pattern select type
//   MODE_ALL_ON    - all LEDs lit
//   MODE_BLINK     - all LEDs toggle on each step
//   MODE_SCAN      - single lit LED bouncing end to end
//   MODE_COUNT     - binary up-counter shown on the LEDs
package led_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_ALL_ON = 2'd0;
    localparam mode_t MODE_BLINK  = 2'd1;
    localparam mode_t MODE_SCAN   = 2'd2;
    localparam mode_t MODE_COUNT  = 2'd3;

endpackage

// File: rtl/led_prescaler.sv
// led_prescaler: divides clk down to a step rate.
//   clk  in   clock, all state on rising edge
//   rst  in   asynchronous active-high reset
//   tick out  high for the single cycle in which the count equals DIV-1
module led_prescaler #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == CntLast);
        cnt_d = tick ? '0 : cnt_q + CntW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern.sv
// led_pattern: LED pattern generator with global PWM brightness.
//   clk   in   clock, all state on rising edge
//   rst   in   asynchronous active-high reset
//   mode  in   pattern select (ALL_ON, BLINK, SCAN, COUNT)
//   duty  in   brightness; 0 = dark, all-ones = fully on
//   leds  out  registered LED drive, 1 = lit
//   step  out  registered one-cycle pulse per pattern step
module led_pattern
    import led_pkg::*;
#(
    parameter int unsigned N_LEDS  = 8,
    parameter int unsigned CLK_HZ  = 12000000,
    parameter int unsigned STEP_HZ = 4,
    parameter int unsigned PWM_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic [PWM_W-1:0]  duty,
    output logic [N_LEDS-1:0] leds,
    output logic              step
);

    localparam int unsigned DIV = CLK_HZ / STEP_HZ;

    logic tick;

    led_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    logic [N_LEDS-1:0] pattern_q, pattern_d;
    logic [N_LEDS-1:0] leds_q, leds_d;
    logic [PWM_W-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic              dir_up_q, dir_up_d;
    logic              load_q, load_d;
    logic              step_q, step_d;
    mode_t             mode_q, mode_d;
    logic              pwm_en;

    function automatic logic [N_LEDS-1:0] load_value(input mode_t m);
        case (m)
            MODE_SCAN:  return N_LEDS'(1);
            MODE_COUNT: return '0;
            default:    return '1;
        endcase
    endfunction

    always_comb begin
        pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
        // All-ones duty must be solidly on, not on for 2^PWM_W-1 of 2^PWM_W cycles.
        pwm_en    = (&duty) || (pwm_cnt_q < duty);
        leds_d    = pattern_q & {N_LEDS{pwm_en}};
        step_d    = tick;
        mode_d    = mode;
        load_d    = 1'b0;
        pattern_d = pattern_q;
        dir_up_d  = dir_up_q;

        // A load swallows a coincident tick: the new pattern starts unstepped.
        if (load_q || (mode != mode_q)) begin
            pattern_d = load_value(mode);
            dir_up_d  = 1'b1;
        end else if (tick) begin
            case (mode_q)
                MODE_BLINK: pattern_d = ~pattern_q;
                MODE_SCAN: begin
                    if (N_LEDS > 1) begin
                        if (dir_up_q) begin
                            pattern_d = pattern_q << 1;
                            if (pattern_d[N_LEDS-1]) dir_up_d = 1'b0;
                        end else begin
                            pattern_d = pattern_q >> 1;
                            if (pattern_d[0]) dir_up_d = 1'b1;
                        end
                    end
                end
                MODE_COUNT: pattern_d = pattern_q + N_LEDS'(1);
                default:    pattern_d = pattern_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern_q <= '0;
            leds_q    <= '0;
            pwm_cnt_q <= '0;
            dir_up_q  <= 1'b1;
            load_q    <= 1'b1;
            step_q    <= 1'b0;
            mode_q    <= MODE_ALL_ON;
        end else begin
            pattern_q <= pattern_d;
            leds_q    <= leds_d;
            pwm_cnt_q <= pwm_cnt_d;
            dir_up_q  <= dir_up_d;
            load_q    <= load_d;
            step_q    <= step_d;
            mode_q    <= mode_d;
        end
    end

    assign leds = leds_q;
    assign step = step_q;

endmodule

// File: tb/tb_led_pattern.sv
// tb_led_pattern: self-checking bench for led_pattern with a 4-cycle step
// period and 4-bit PWM. Outputs are sampled 1 ns after each rising edge.
module tb_led_pattern;

    localparam int unsigned N_LEDS  = 8;
    localparam int unsigned CLK_HZ  = 16;
    localparam int unsigned STEP_HZ = 4;
    localparam int unsigned PWM_W   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        mode;
    logic [PWM_W-1:0]  duty;
    logic [N_LEDS-1:0] leds;
    logic              step;

    int errors = 0;
    int checks = 0;

    // Expected LED value after each upcoming step pulse.
    logic [7:0] sb[$];

    typedef struct {
        logic [1:0]       mode;
        logic [PWM_W-1:0] duty;
        logic [7:0]       exp_lit;
        int               exp_on;
    } pwm_vec_t;

    pwm_vec_t vecs[6];

    led_pattern #(
        .N_LEDS  (N_LEDS),
        .CLK_HZ  (CLK_HZ),
        .STEP_HZ (STEP_HZ),
        .PWM_W   (PWM_W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .mode (mode),
        .duty (duty),
        .leds (leds),
        .step (step)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance until step is sampled high, at most 8 cycles.
    task automatic wait_step();
        int n = 0;
        while (step !== 1'b1 && n < 8) begin
            cyc();
            n++;
        end
        chk8("step_wait", {7'd0, step}, 8'h01);
    endtask

    // For each queued value: find the step pulse, then expect leds to show the
    // value for the four cycles that follow it.
    task automatic check_steps(input int n, input string name);
        logic [7:0] exp;
        for (int s = 0; s < n; s++) begin
            wait_step();
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s: got empty scoreboard, expected an entry", name);
                return;
            end
            exp = sb.pop_front();
            for (int h = 0; h < 4; h++) begin
                cyc();
                chk8(name, leds, exp);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         on_cnt;
        int         bad_cnt;
        logic [7:0] scan_exp [16];

        vecs[0] = '{mode: 2'd0, duty: 4'hF, exp_lit: 8'hFF, exp_on: 16};
        vecs[1] = '{mode: 2'd0, duty: 4'h4, exp_lit: 8'hFF, exp_on: 4};
        vecs[2] = '{mode: 2'd0, duty: 4'h0, exp_lit: 8'hFF, exp_on: 0};
        vecs[3] = '{mode: 2'd0, duty: 4'h1, exp_lit: 8'hFF, exp_on: 1};
        vecs[4] = '{mode: 2'd0, duty: 4'h8, exp_lit: 8'hFF, exp_on: 8};
        vecs[5] = '{mode: 2'd0, duty: 4'hE, exp_lit: 8'hFF, exp_on: 14};

        scan_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                     8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};

        // Reset state
        rst  = 1'b1;
        mode = 2'd0;
        duty = 4'hF;
        repeat (3) cyc();
        chk8("rst_leds", leds, 8'h00);
        chk8("rst_step", {7'd0, step}, 8'h00);

        // Boot: leds all on from second clock, step after clocks 4, 8, 12
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            chk8("boot_step", {7'd0, step}, 8'((k % 4) == 0));
            if (k >= 2) chk8("boot_leds", leds, 8'hFF);
        end

        // PWM brightness table, ALL_ON pattern
        for (int i = 0; i < 6; i++) begin
            mode = vecs[i].mode;
            duty = vecs[i].duty;
            cyc();
            cyc();
            on_cnt  = 0;
            bad_cnt = 0;
            for (int c = 0; c < 16; c++) begin
                cyc();
                if (leds === vecs[i].exp_lit) on_cnt++;
                else if (leds !== 8'h00) bad_cnt++;
            end
            chk_int("pwm_on_cycles", on_cnt, vecs[i].exp_on);
            chk_int("pwm_bad_value", bad_cnt, 0);
        end
        duty = 4'hF;

        // BLINK
        wait_step();
        mode = 2'd1;
        cyc();
        for (int h = 0; h < 3; h++) begin
            cyc();
            chk8("blink_load", leds, 8'hFF);
        end
        for (int k = 0; k < 6; k++) sb.push_back((k % 2 == 0) ? 8'h00 : 8'hFF);
        check_steps(6, "blink");

        // COUNT across the wrap
        wait_step();
        mode = 2'd3;
        cyc();
        for (int h = 0; h < 3; h++) begin
            cyc();
            chk8("count_load", leds, 8'h00);
        end
        for (int k = 1; k <= 257; k++) sb.push_back(8'(k));
        check_steps(257, "count");

        // Switch COUNT -> SCAN in the cycle the tick is high: load wins
        wait_step();
        repeat (3) cyc();
        mode = 2'd2;
        cyc();
        chk8("tick_align", {7'd0, step}, 8'h01);
        for (int h = 0; h < 4; h++) begin
            cyc();
            chk8("scan_load_vs_tick", leds, 8'h01);
        end
        for (int k = 0; k < 16; k++) sb.push_back(scan_exp[k]);
        check_steps(16, "scan");

        // Asynchronous reset mid-SCAN, away from any rising edge
        chk8("pre_rst_leds", leds, 8'h04);
        #3;
        rst = 1'b1;
        #1;
        chk8("async_rst_leds", leds, 8'h00);
        chk8("async_rst_step", {7'd0, step}, 8'h00);
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        cyc();
        chk8("restart_scan_load", leds, 8'h01);
        cyc();
        cyc();
        chk8("restart_step", {7'd0, step}, 8'h01);
        sb.push_back(8'h02);
        sb.push_back(8'h04);
        check_steps(2, "scan_restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_pattern.md
LED_PATTERN -- requirements
Module: led_pattern

Interface
REQ-001 Parameter N_LEDS, default 8, number of LED outputs (>=1).
REQ-002 Parameter CLK_HZ, default 12000000, input clock frequency.
REQ-003 Parameter STEP_HZ, default 4, pattern step rate; DIV = CLK_HZ/STEP_HZ SHALL be >=2.
REQ-004 Parameter PWM_W, default 8, brightness resolution in bits.
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 mode  in  2  pattern select: 0 ALL_ON, 1 BLINK, 2 SCAN, 3 COUNT.
REQ-008 duty  in  PWM_W  brightness; 0 = dark, all-ones = fully on.
REQ-009 leds  out  N_LEDS  registered LED drive, 1 = lit.
REQ-010 step  out  1  registered one-cycle pulse per pattern step.

Function
REQ-011 Prescaler SHALL count 0..DIV-1, wrap to 0; internal tick asserted the cycle count equals DIV-1.
REQ-012 step SHALL be the tick delayed one cycle (exactly one-cycle pulse every DIV cycles).
REQ-013 PWM counter SHALL free-run over PWM_W bits, wrapping all-ones -> 0.
REQ-014 pwm_en SHALL be 1 when duty is all-ones, else when pwm_cnt < duty (unsigned).
REQ-015 leds SHALL equal pattern AND replicate(pwm_en), registered: one cycle latency from pattern/pwm_cnt/duty.
REQ-016 mode SHALL be registered into mode_q each cycle; mode_q != mode, or load flag set, SHALL trigger pattern load next cycle, taking priority over tick.
REQ-017 Load values: ALL_ON all ones; BLINK all ones; SCAN bit 0 only, direction up; COUNT zero.
REQ-018 ALL_ON: pattern held all ones; tick ignored.
REQ-019 BLINK: on tick pattern SHALL invert (all ones <-> all zeros).
REQ-020 SCAN: on tick one-hot bit moves one position in current direction; at bit N_LEDS-1 direction flips to down in the same cycle the bit arrives; at bit 0 flips to up; N_LEDS=1 holds bit 0.
REQ-021 COUNT: on tick pattern increments modulo 2^N_LEDS, all-ones wraps to 0.
REQ-022 Prescaler and PWM counter SHALL NOT be disturbed by mode changes.
REQ-023 Simultaneous load and tick: load wins, tick is consumed (no step applied to new pattern).

Reset
REQ-024 While rst high: prescaler 0, pwm_cnt 0, pattern 0, direction up, mode_q 0, leds 0, step 0, load flag 1.
REQ-025 First clock after rst falls SHALL load pattern for the then-current mode; leds valid from the second clock.
REQ-026 rst asserted mid-pattern SHALL clear all state immediately without waiting for a clock edge.

Structure
REQ-027 Shared package led_pkg SHALL hold mode constants (MODE_ALL_ON, MODE_BLINK, MODE_SCAN, MODE_COUNT) and the 2-bit mode type.
REQ-028 Prescaler SHALL be one sub-module, led_prescaler (parameter DIV, outputs tick); pattern and PWM logic stay in led_pattern.
REQ-029 Synthesisable for iCE40 with no vendor primitives; mode=0, duty all-ones reproduces previous all-LEDs-on behaviour.

Verification (sim params CLK_HZ=16, STEP_HZ=4, DIV=4, PWM_W=4, N_LEDS=8)
REQ-030 Reset release, mode=0, duty=15 -> leds=0xFF from second clock, step pulses every 4 cycles, first at cycle 5.
REQ-031 mode=1, duty=15 -> leds 0xFF, 0x00, 0xFF alternating, each held 4 cycles.
REQ-032 mode=2, duty=15, 16 ticks -> leds 0x01,0x02,...,0x80,0x40,...,0x01,0x02; no repeat of 0x80 at turn.
REQ-033 mode=3, 257 ticks -> leds 0x00..0xFF then 0x00 after wrap.
REQ-034 mode=0, duty=4 -> leds 0xFF exactly 4 of every 16 cycles; duty=0 -> leds constantly 0x00.
REQ-035 Change mode 3->2 on same cycle as tick -> leds 0x01 after load, tick not applied; rst pulsed mid-SCAN -> leds 0x00 asynchronously.
